keypad_scan: RTL

- Scans a 4x4 active-low matrix keypad, debounces the press and emits a 4-bit key code with a one-cycle valid strobe.
- Sits directly upstream of the seven-segment display driver, which latches key_num when keyboard_en is high.
- Single clock domain. Row inputs come from board pins and are synchronised inside the block.

---
 rtl/keypad_scan.sv | 119 +++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits {row_idx, col_idx} on key_num with a one-cycle keyboard_en strobe.
module keypad_scan #(
  parameter int SCAN_DIV     = 20000,
  parameter int DEBOUNCE_CNT = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_num,
  output logic       keyboard_en,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [31:0] DIV_LAST = 32'(SCAN_DIV - 1);
  localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CNT - 1);

  state_t      state;
  logic [3:0]  row_m;
  logic [3:0]  rows_s;
  logic [3:0]  cap;
  logic [1:0]  col_idx;
  logic [1:0]  row_idx;
  logic [31:0] div;
  logic [31:0] db;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m  <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      row_m  <= row;
      rows_s <= row_m;
    end
  end

  // Lowest low row in the captured pattern wins when several keys share a column.
  always_comb begin
    row_idx = 2'd3;
    if (!cap[2]) row_idx = 2'd2;
    if (!cap[1]) row_idx = 2'd1;
    if (!cap[0]) row_idx = 2'd0;
  end

  assign col = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      div         <= 32'd0;
      db          <= 32'd0;
      cap         <= 4'hF;
      key_num     <= 4'h0;
      keyboard_en <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      keyboard_en <= 1'b0;
      case (state)
        SCAN: begin
          if (div == DIV_LAST) begin
            if (rows_s == 4'hF) begin
              col_idx <= col_idx + 2'd1;
              div     <= 32'd0;
            end else begin
              cap   <= rows_s;
              db    <= 32'd0;
              state <= DEBOUNCE;
            end
          end else begin
            div <= div + 32'd1;
          end
        end
        DEBOUNCE: begin
          if (rows_s == cap) begin
            if (db == DB_LAST) begin
              key_num     <= {row_idx, col_idx};
              keyboard_en <= 1'b1;
              key_held    <= 1'b1;
              state       <= PRESSED;
            end else begin
              db <= db + 32'd1;
            end
          end else begin
            col_idx <= col_idx + 2'd1;
            div     <= 32'd0;
            state   <= SCAN;
          end
        end
        PRESSED: begin
          if (rows_s == 4'hF) begin
            db    <= 32'd0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Any bounce back low restarts the release window.
          if (rows_s == 4'hF) begin
            if (db == DB_LAST) begin
              key_held <= 1'b0;
              col_idx  <= col_idx + 2'd1;
              div      <= 32'd0;
              state    <= SCAN;
            end else begin
              db <= db + 32'd1;
            end
          end else begin
            db <= 32'd0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
